// File: rtl/case4_pkg.sv
// Shared types and constants for the case4 cover and its preimage enumerator.
package case4_pkg;

    localparam int unsigned CASE4_IN_W  = 7;
    localparam int unsigned CASE4_OUT_W = 3;
    localparam int unsigned CASE4_CNT_W = 8;

    localparam logic [CASE4_IN_W-1:0] CASE4_LAST_VEC = 7'h7F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

    // Image of one input vector, MSB first as {x,y,z}
    typedef struct packed {
        logic x;
        logic y;
        logic z;
    } case4_out_t;

endpackage

// File: rtl/case4_eval.sv
// Combinational case4 cover: {a,b,c,d,e,f,g} -> {x,y,z}, a is the MSB.
module case4_eval
    import case4_pkg::*;
(
    input  logic [CASE4_IN_W-1:0] i_vec,
    output case4_out_t            o_img_c
);

    logic w_a, w_b, w_c, w_d, w_e, w_f, w_g;

    assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g} = i_vec;

    assign o_img_c.x = w_a & w_b & w_e;
    assign o_img_c.y = ~(w_b & w_d & w_e);
    assign o_img_c.z = ~(w_c & w_d & w_e & w_f & w_g);

endmodule

// File: rtl/case4_preimage_enum.sv
// Walks all 128 case4 input vectors and streams those whose image equals the target.
// Define CASE4_PREIMAGE_COUNT_EN to build the match_count register.
module case4_preimage_enum
    import case4_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CASE4_OUT_W-1:0] target,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CASE4_IN_W-1:0]  out_vec,
    output logic                   busy,
    output logic                   done,
    output logic [CASE4_CNT_W-1:0] match_count
);

    state_e                 r_state, w_state_nxt;
    logic [CASE4_IN_W-1:0]  r_vec, w_vec_nxt;
    logic [CASE4_OUT_W-1:0] r_target, w_target_nxt;
    logic                   r_out_valid, w_out_valid_nxt;
    logic [CASE4_IN_W-1:0]  r_out_vec, w_out_vec_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_done, w_done_nxt;
    case4_out_t             w_img_c;
    logic                   w_match;
    logic                   w_last;

`ifdef CASE4_PREIMAGE_COUNT_EN
    logic [CASE4_CNT_W-1:0] r_match_count, w_match_count_nxt;
`endif

    case4_eval u_eval (
        .i_vec   (r_vec),
        .o_img_c (w_img_c)
    );

    assign w_match = (CASE4_OUT_W'(w_img_c) == r_target);
    assign w_last  = (r_vec == CASE4_LAST_VEC);

    // Next-state and next-register values; busy/done follow the next state
    always_comb begin
        w_state_nxt     = r_state;
        w_vec_nxt       = r_vec;
        w_target_nxt    = r_target;
        w_out_valid_nxt = r_out_valid;
        w_out_vec_nxt   = r_out_vec;
`ifdef CASE4_PREIMAGE_COUNT_EN
        w_match_count_nxt = r_match_count;
`endif
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_target_nxt = target;
                    w_vec_nxt    = '0;
`ifdef CASE4_PREIMAGE_COUNT_EN
                    w_match_count_nxt = '0;
`endif
                    w_state_nxt  = SCAN;
                end
            end
            SCAN: begin
                if (w_match) begin
                    w_out_vec_nxt   = r_vec;
                    w_out_valid_nxt = 1'b1;
`ifdef CASE4_PREIMAGE_COUNT_EN
                    w_match_count_nxt = r_match_count + CASE4_CNT_W'(1);
`endif
                    w_state_nxt     = HOLD;
                end else if (w_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_vec_nxt = r_vec + CASE4_IN_W'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_vec_nxt   = r_vec + CASE4_IN_W'(1);
                        w_state_nxt = SCAN;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
        w_done_nxt = (w_state_nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_vec       <= '0;
            r_target    <= '0;
            r_out_valid <= 1'b0;
            r_out_vec   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_vec       <= w_vec_nxt;
            r_target    <= w_target_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_vec   <= w_out_vec_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

`ifdef CASE4_PREIMAGE_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_match_count <= '0;
        end else begin
            r_match_count <= w_match_count_nxt;
        end
    end

    assign match_count = r_match_count;
`else
    assign match_count = CASE4_CNT_W'(0);
`endif

    assign out_valid = r_out_valid;
    assign out_vec   = r_out_vec;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_case4_preimage_enum.sv
// Directed bench for case4_preimage_enum; expected vectors come from an independent case4 model.
module tb_case4_preimage_enum;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] target;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_vec;
    logic       busy;
    logic       done;
    logic [7:0] match_count;

    int         total;
    int         failed;
    logic [6:0] got[$];
    logic [6:0] exp_q[$];
    int         mc_at_done;
    int         n_to_done;
    bit         timed_out;
    int         stall_errs;
    logic       busy_at_1;

    case4_preimage_enum dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .target      (target),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_vec     (out_vec),
        .busy        (busy),
        .done        (done),
        .match_count (match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] ref_img(input logic [6:0] v);
        logic a, b, c, d, e, f, g;
        {a, b, c, d, e, f, g} = v;
        return {a & b & e, ~(b & d & e), ~(c & d & e & f & g)};
    endfunction

    function automatic int exp_count(input int n);
`ifdef CASE4_PREIMAGE_COUNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic build_expected(input logic [2:0] tgt);
        logic [6:0] v;
        exp_q.delete();
        for (int i = 0; i < 128; i++) begin
            v = 7'(i);
            if (ref_img(v) == tgt) exp_q.push_back(v);
        end
    endtask

    // Runs one enumeration, collecting handshaken vectors; optionally pokes start mid-run
    task automatic run_enum(input logic [2:0] tgt, input bit rand_ready, input int poke_at,
                            input int max_cycles);
        bit         have_stall;
        logic [6:0] stall_vec;
        got.delete();
        stall_errs = 0;
        timed_out  = 1'b1;
        n_to_done  = 0;
        mc_at_done = -1;
        have_stall = 1'b0;
        stall_vec  = '0;
        busy_at_1  = 1'b0;
        @(negedge clk);
        target    = tgt;
        out_ready = 1'b1;
        start     = 1'b1;
        for (int i = 1; i <= max_cycles; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 1) busy_at_1 = busy;
            if (i == poke_at) begin
                start  = 1'b1;
                target = ~tgt;
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (have_stall && (!out_valid || out_vec !== stall_vec)) stall_errs++;
            if (out_valid && out_ready) begin
                got.push_back(out_vec);
                have_stall = 1'b0;
            end else if (out_valid) begin
                have_stall = 1'b1;
                stall_vec  = out_vec;
            end else begin
                have_stall = 1'b0;
            end
            if (done) begin
                n_to_done  = i;
                mc_at_done = int'(match_count);
                timed_out  = 1'b0;
                break;
            end
        end
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        start     = 1'b0;
        target    = 3'b000;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_vec !== 7'h00) begin failed++; $display("FAIL reset_out_vec got=%h want=00", out_vec); end
        total++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin failed++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (match_count !== 8'd0) begin failed++; $display("FAIL reset_count got=%0d want=0", match_count); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_all_ones;
        int bad;
        run_enum(3'b111, 1'b0, 0, 400);
        build_expected(3'b111);
        total++; if (timed_out) begin failed++; $display("FAIL t111_timeout got=timeout want=done"); end
        total++; if (got.size() != 8) begin failed++; $display("FAIL t111_count got=%0d want=8", got.size()); end
        total++; if (got.size() < 1 || got[0] !== 7'h64) begin failed++; $display("FAIL t111_first got=%h want=64", got.size() > 0 ? got[0] : 7'hxx); end
        total++; if (got.size() < 1 || got[got.size()-1] !== 7'h77) begin failed++; $display("FAIL t111_last got=%h want=77", got.size() > 0 ? got[got.size()-1] : 7'hxx); end
        bad = (got.size() == exp_q.size()) ? 0 : 1;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) bad++;
        total++; if (bad != 0) begin failed++; $display("FAIL t111_seq got=%0d_diffs want=0", bad); end
        total++; if (n_to_done != 137) begin failed++; $display("FAIL t111_done_cycle got=%0d want=137", n_to_done); end
        total++; if (mc_at_done != exp_count(8)) begin failed++; $display("FAIL t111_match_count got=%0d want=%0d", mc_at_done, exp_count(8)); end
    endtask

    task automatic test_terminal;
        run_enum(3'b100, 1'b0, 0, 400);
        total++; if (got.size() != 1 || got[0] !== 7'h7F) begin failed++; $display("FAIL t100_emit got=%0d_items want=1_item_7f", got.size()); end
        total++; if (n_to_done != 130) begin failed++; $display("FAIL t100_done_cycle got=%0d want=130", n_to_done); end
        total++; if (mc_at_done != exp_count(1)) begin failed++; $display("FAIL t100_match_count got=%0d want=%0d", mc_at_done, exp_count(1)); end
    endtask

    task automatic test_unreachable;
        run_enum(3'b110, 1'b0, 0, 400);
        total++; if (busy_at_1 !== 1'b1) begin failed++; $display("FAIL t110_busy_after_start got=%b want=1", busy_at_1); end
        total++; if (got.size() != 0) begin failed++; $display("FAIL t110_emit got=%0d want=0", got.size()); end
        total++; if (n_to_done != 129) begin failed++; $display("FAIL t110_done_cycle got=%0d want=129", n_to_done); end
        total++; if (mc_at_done != 0) begin failed++; $display("FAIL t110_match_count got=%0d want=0", mc_at_done); end
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin failed++; $display("FAIL t110_after_done got=done%b_busy%b want=done0_busy0", done, busy); end
    endtask

    task automatic test_backpressure;
        int bad;
        run_enum(3'b011, 1'b1, 0, 3000);
        build_expected(3'b011);
        total++; if (timed_out) begin failed++; $display("FAIL t011_timeout got=timeout want=done"); end
        total++; if (got.size() != 102) begin failed++; $display("FAIL t011_count got=%0d want=102", got.size()); end
        total++; if (got.size() < 1 || got[0] !== 7'h00) begin failed++; $display("FAIL t011_first got=%h want=00", got.size() > 0 ? got[0] : 7'hxx); end
        bad = (got.size() == exp_q.size()) ? 0 : 1;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) bad++;
        total++; if (bad != 0) begin failed++; $display("FAIL t011_seq got=%0d_diffs want=0", bad); end
        total++; if (stall_errs != 0) begin failed++; $display("FAIL t011_stall_stable got=%0d want=0", stall_errs); end
        total++; if (mc_at_done != exp_count(102)) begin failed++; $display("FAIL t011_match_count got=%0d want=%0d", mc_at_done, exp_count(102)); end
    endtask

    task automatic test_reset_mid_hold;
        bit ok;
        @(negedge clk);
        out_ready = 1'b0;
        target    = 3'b010;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (out_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        total++; if (!ok || out_vec !== 7'h1F) begin failed++; $display("FAIL t010_first got=%h want=1f", out_vec); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (out_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        total++; if (!ok || out_vec !== 7'h5F) begin failed++; $display("FAIL t010_second got=%h want=5f", out_vec); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if ({out_valid, out_vec, busy, done, match_count} !== 18'd0)
            begin failed++; $display("FAIL t010_rst_hold got=v%b_vec%h_b%b_d%b_c%0d want=all_zero", out_valid, out_vec, busy, done, match_count); end
        run_enum(3'b010, 1'b0, 0, 400);
        total++; if (got.size() != 2 || got[0] !== 7'h1F || got[1] !== 7'h5F) begin failed++; $display("FAIL t010_restart got=%0d_items want=1f_5f", got.size()); end
        total++; if (mc_at_done != exp_count(2)) begin failed++; $display("FAIL t010_match_count got=%0d want=%0d", mc_at_done, exp_count(2)); end
    endtask

    task automatic test_start_while_busy;
        int bad;
        run_enum(3'b111, 1'b0, 20, 400);
        build_expected(3'b111);
        bad = (got.size() == exp_q.size()) ? 0 : 1;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) bad++;
        total++; if (bad != 0) begin failed++; $display("FAIL busy_start_seq got=%0d_diffs want=0", bad); end
        total++; if (n_to_done != 137) begin failed++; $display("FAIL busy_start_done_cycle got=%0d want=137", n_to_done); end
        total++; if (mc_at_done != exp_count(8)) begin failed++; $display("FAIL busy_start_count got=%0d want=%0d", mc_at_done, exp_count(8)); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin failed++; $display("FAIL busy_start_idle got=%b want=0", busy); end
    endtask

    initial begin
        total  = 0;
        failed = 0;
        rst       = 1'b1;
        start     = 1'b0;
        target    = 3'b000;
        out_ready = 1'b1;
        test_reset();
        test_all_ones();
        test_terminal();
        test_unreachable();
        test_backpressure();
        test_reset_mid_hold();
        test_start_while_busy();
        $display("%0d/%0d checks passed", total - failed, total);
        $finish;
    end

endmodule

// File: doc/case4_preimage_enum.md
# case4_preimage_enum

Sequential inverse of the `case4` cover (x = a&b&e, y = ~(b&d&e), z = ~(c&d&e&f&g)). Given a target output triple, it walks all 128 input vectors {a,b,c,d,e,f,g} in ascending order. Each vector whose image equals the target is emitted on a valid/ready stream. It sits beside the synthesized `case4` netlist as the enumeration and equivalence-check engine for the flow's results.

## Interface
Parameters:
- none; the vector width is fixed at 7 and the output width at 3 by the `case4` function.

Ports:
- `clk  in  1  sole clock, rising edge`
- `rst  in  1  synchronous, active-high reset`
- `start  in  1  begin an enumeration; sampled only in IDLE`
- `target  in  3  {x,y,z} to invert; captured on accepted start`
- `out_valid  out  1  out_vec holds a preimage`
- `out_ready  in  1  consumer accepts out_vec`
- `out_vec  out  7  {a,b,c,d,e,f,g}, a = MSB`
- `busy  out  1  high in SCAN/HOLD/DONE`
- `done  out  1  one-cycle pulse at end of enumeration`
- `match_count  out  8  number of preimages found (see Configuration)`

## Operation
- State machine: IDLE, SCAN, HOLD, DONE.
- IDLE:
  - on start, capture target, clear vec counter and match_count, go to SCAN.
- SCAN:
  - evaluate `case4` on vec.
  - On match: register out_vec = vec, set out_valid, increment match_count, go to HOLD.
  - On no match at vec = 127: go to DONE.
  - Otherwise vec++.
- HOLD:
  - out_valid = 1; out_vec stable until the handshake.
  - On out_valid & out_ready: clear out_valid. Go to DONE if vec = 127; else vec++ and go to SCAN.
- DONE:
  - done = 1 for exactly one cycle, then IDLE.
  - match_count holds its value until the next start.
- The counter is 7 bits and never wraps: 127 is terminal.
- match_count is 8 bits, max 128, no saturation needed.
- start outside IDLE is ignored. target changes after capture are ignored.
- Unreachable targets (e.g. 3'b110) produce no out_valid, then done with match_count = 0.

## Timing
- Reset values: out_valid=0, out_vec=0, busy=0, done=0, match_count=0, state=IDLE, vec=0.
- start at cycle T: busy=1 from T+1, and vector 0 is evaluated in T+1.
- Match evaluated in cycle C: out_valid=1 from C+1.
- Minimum spacing between emissions is 2 cycles: a HOLD cycle, then a SCAN cycle.
- Full scan with no matches: 128 SCAN cycles, then 1 DONE cycle. done is high at T+129 and busy falls at T+130.
- Backpressure: HOLD persists indefinitely while out_ready=0; no data loss or reorder.
- rst during any state: returns to reset values the next cycle, and any pending out_vec is dropped.

## Configuration
- `CASE4_PREIMAGE_COUNT_EN` defined:
  - the match_count register and its increment are built.
- Not defined:
  - match_count is tied to 8'd0 and no counter register exists.
  - All other behaviour is unchanged.

## Structure
- Shared package `case4_pkg`:
  - state enum type (IDLE/SCAN/HOLD/DONE).
  - `CASE4_IN_W`=7, `CASE4_OUT_W`=3.
  - `CASE4_LAST_VEC`=7'h7F.
- One sub-module `case4_eval`:
  - purely combinational, vec[6:0] -> {x,y,z}.
  - Same function as the `case4` netlist, so the bench can cross-check it against the netlist directly.
- Top module holds the FSM, vec counter, output register and optional count.

## Test plan
- target=3'b111, out_ready=1:
  - 8 emissions, the first 7'h64 and the last 7'h77, strictly ascending.
  - match_count=8 at done.
- target=3'b100:
  - single emission 7'h7F, the terminal vector.
  - Then done; match_count=1.
- target=3'b110:
  - no out_valid.
  - done exactly 129 cycles after start; match_count=0.
- target=3'b011 with out_ready toggling randomly:
  - 102 emissions; the first is 7'h00.
  - out_vec stays stable across stall cycles, with no duplicates and none missing.
- target=3'b010:
  - emissions 7'h1F and 7'h5F only.
  - Assert rst mid-HOLD on the second: next cycle all outputs are 0 and state is IDLE.
  - A start after that restarts the enumeration cleanly.
- start pulsed while busy:
  - ignored, with no change to target or sequence.
  - Build without `CASE4_PREIMAGE_COUNT_EN`: match_count stays 0 and the emission sequence is identical.
